// File: rtl/pipe_ctrl_pkg.sv
// Shared types and helpers for the pipeline sequencer (pipe_ctrl).
package pipe_ctrl_pkg;

   localparam int unsigned ADDR_W = 32;

   typedef enum logic [1:0] {
      PCTRL_IDLE  = 2'd0,
      PCTRL_HOLD  = 2'd1,
      PCTRL_FLUSH = 2'd2
   } pctrl_state_e;

   // Bits needed to hold values 0..max_val, never less than one bit.
   function automatic int unsigned cnt_width(input int unsigned max_val);
      return (max_val < 2) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/pipe_ctrl_hold_watchdog.sv
// hold_watchdog: counts consecutive cycles with en=1 and raises a sticky timeout
// once HOLD_TIMEOUT is reached. HOLD_TIMEOUT=0 disables the watchdog entirely.
module hold_watchdog
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned HOLD_TIMEOUT = 64
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic timeout_o
);

   if (HOLD_TIMEOUT == 0) begin : g_off
      logic unused_en;
      assign unused_en = en;
      assign timeout_o = 1'b0;
   end else begin : g_on
      localparam int unsigned CW = cnt_width(HOLD_TIMEOUT);
      logic [CW-1:0] cnt;

      // Saturating run-length counter; timeout sticks until reset.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            cnt       <= '0;
            timeout_o <= 1'b0;
         end else if (en) begin
            if (cnt != CW'(HOLD_TIMEOUT)) cnt <= cnt + CW'(1);
            if (cnt >= CW'(HOLD_TIMEOUT - 1)) timeout_o <= 1'b1;
         end else begin
            cnt <= '0;
         end
      end
   end

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: sequencer behind the execute stage. Issues a registered PC redirect,
// a FLUSH_CYCLES-long flush of if_id/id_ex, and a front-end hold; a watchdog flags
// holds that never end. Optional macro PIPE_CTRL_STATS_EN adds redirect/stall counters.
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned FLUSH_CYCLES = 2,
   parameter int unsigned HOLD_TIMEOUT = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              jump_ena_i,
   input  logic [ADDR_W-1:0] jump_addr_i,
   input  logic              hold_flag_i,
   input  logic              ext_hold_i,
   output logic              redirect_o,
   output logic [ADDR_W-1:0] redirect_addr_o,
   output logic              flush_o,
   output logic              hold_o,
`ifdef PIPE_CTRL_STATS_EN
   output logic [31:0]       flush_cnt_o,
   output logic [31:0]       stall_cnt_o,
`endif
   output logic              hold_timeout_o
);

   localparam int unsigned CNT_W = cnt_width(FLUSH_CYCLES);

   pctrl_state_e     state;
   logic [CNT_W-1:0] cnt;
   logic             hold_req;
   logic             accept_jump;

   assign hold_req    = hold_flag_i | ext_hold_i;
   // Jumps arriving during FLUSH come from the wrong path and are dropped.
   assign accept_jump = jump_ena_i & (state != PCTRL_FLUSH);
   // Same-cycle jump wins over hold; FLUSH only inserts bubbles, never stalls.
   assign hold_o      = hold_req & ~jump_ena_i & (state != PCTRL_FLUSH);

   // Sequencer FSM with registered redirect/flush outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state           <= PCTRL_IDLE;
         cnt             <= '0;
         redirect_o      <= 1'b0;
         redirect_addr_o <= '0;
         flush_o         <= 1'b0;
      end else begin
         redirect_o <= 1'b0;
         case (state)
            PCTRL_IDLE, PCTRL_HOLD: begin
               if (accept_jump) begin
                  state           <= PCTRL_FLUSH;
                  cnt             <= CNT_W'(FLUSH_CYCLES);
                  redirect_o      <= 1'b1;
                  redirect_addr_o <= jump_addr_i;
                  flush_o         <= 1'b1;
               end else begin
                  state <= hold_req ? PCTRL_HOLD : PCTRL_IDLE;
               end
            end
            PCTRL_FLUSH: begin
               if (cnt == CNT_W'(1)) begin
                  state   <= hold_req ? PCTRL_HOLD : PCTRL_IDLE;
                  cnt     <= '0;
                  flush_o <= 1'b0;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            default: begin
               state   <= PCTRL_IDLE;
               cnt     <= '0;
               flush_o <= 1'b0;
            end
         endcase
      end
   end

   hold_watchdog #(
      .HOLD_TIMEOUT (HOLD_TIMEOUT)
   ) u_hold_watchdog (
      .clk       (clk),
      .rst       (rst),
      .en        (state == PCTRL_HOLD),
      .timeout_o (hold_timeout_o)
   );

`ifdef PIPE_CTRL_STATS_EN
   // Free-running wrap-around counters of taken redirects and stalled cycles.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         flush_cnt_o <= '0;
         stall_cnt_o <= '0;
      end else begin
         if (accept_jump) flush_cnt_o <= flush_cnt_o + 32'd1;
         if (hold_o)      stall_cnt_o <= stall_cnt_o + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Testbench for pipe_ctrl: directed scenarios plus randomized traffic, all checked
// against a cycle-level behavioural model of the sequencer.
module tb_pipe_ctrl;

   localparam int unsigned FC = 2;
   localparam int unsigned HT = 64;

   logic        clk = 1'b0;
   logic        rst;
   logic        jump_ena_i;
   logic [31:0] jump_addr_i;
   logic        hold_flag_i;
   logic        ext_hold_i;
   logic        redirect_o;
   logic [31:0] redirect_addr_o;
   logic        flush_o;
   logic        hold_o;
   logic        hold_timeout_o;
`ifdef PIPE_CTRL_STATS_EN
   logic [31:0] flush_cnt_o;
   logic [31:0] stall_cnt_o;
`endif

   always #5 clk = ~clk;

   pipe_ctrl #(
      .FLUSH_CYCLES (FC),
      .HOLD_TIMEOUT (HT)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .jump_ena_i      (jump_ena_i),
      .jump_addr_i     (jump_addr_i),
      .hold_flag_i     (hold_flag_i),
      .ext_hold_i      (ext_hold_i),
      .redirect_o      (redirect_o),
      .redirect_addr_o (redirect_addr_o),
      .flush_o         (flush_o),
      .hold_o          (hold_o),
`ifdef PIPE_CTRL_STATS_EN
      .flush_cnt_o     (flush_cnt_o),
      .stall_cnt_o     (stall_cnt_o),
`endif
      .hold_timeout_o  (hold_timeout_o)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Model: remaining flush cycles, whether the front end is parked in a hold,
   // length of the current hold run, and the expected registered outputs.
   int          m_flush_left;
   bit          m_in_hold;
   int          m_run;
   bit          m_to;
   bit          m_redir;
   logic [31:0] m_addr;
   logic [31:0] m_fcnt;
   logic [31:0] m_scnt;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic bit m_hold();
      return (hold_flag_i | ext_hold_i) && !jump_ena_i && (m_flush_left == 0);
   endfunction

   task automatic model_reset();
      m_flush_left = 0;
      m_in_hold    = 0;
      m_run        = 0;
      m_to         = 0;
      m_redir      = 0;
      m_addr       = '0;
      m_fcnt       = '0;
      m_scnt       = '0;
   endtask

   // Advance the model by one clock edge using the inputs the DUT just sampled.
   task automatic model_step();
      bit hreq;
      hreq = hold_flag_i | ext_hold_i;
      if (m_hold()) m_scnt = m_scnt + 32'd1;
      if (m_in_hold) begin
         m_run = (m_run < HT) ? m_run + 1 : m_run;
         if (HT != 0 && m_run >= HT) m_to = 1;
      end else begin
         m_run = 0;
      end
      m_redir = 0;
      if (m_flush_left > 0) begin
         m_flush_left--;
         if (m_flush_left == 0) m_in_hold = hreq;
      end else if (jump_ena_i) begin
         m_flush_left = FC;
         m_redir      = 1;
         m_addr       = jump_addr_i;
         m_in_hold    = 0;
         m_fcnt       = m_fcnt + 32'd1;
      end else begin
         m_in_hold = hreq;
      end
   endtask

   task automatic check_outputs(input string tag);
      check({tag, "_hold"},     32'(hold_o),         32'(m_hold()));
      check({tag, "_redirect"}, 32'(redirect_o),     32'(m_redir));
      check({tag, "_addr"},     redirect_addr_o,     m_addr);
      check({tag, "_flush"},    32'(flush_o),        32'(m_flush_left > 0));
      check({tag, "_timeout"},  32'(hold_timeout_o), 32'(m_to));
`ifdef PIPE_CTRL_STATS_EN
      check({tag, "_fcnt"},     flush_cnt_o,         m_fcnt);
      check({tag, "_scnt"},     stall_cnt_o,         m_scnt);
`endif
   endtask

   // One cycle: drive after negedge, check mid-cycle, step model at posedge.
   task automatic cycle(input string tag, input logic je, input logic [31:0] ja,
                        input logic hf, input logic eh);
      jump_ena_i  = je;
      jump_addr_i = ja;
      hold_flag_i = hf;
      ext_hold_i  = eh;
      #1;
      check_outputs(tag);
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   task automatic do_reset(input string tag);
      rst         = 1'b1;
      jump_ena_i  = 1'b0;
      jump_addr_i = '0;
      hold_flag_i = 1'b0;
      ext_hold_i  = 1'b0;
      model_reset();
      #1;
      check({tag, "_rst_redirect"}, 32'(redirect_o), 32'd0);
      check({tag, "_rst_flush"},    32'(flush_o),    32'd0);
      check({tag, "_rst_addr"},     redirect_addr_o, 32'd0);
      check({tag, "_rst_timeout"},  32'(hold_timeout_o), 32'd0);
      check_outputs({tag, "_rst"});
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      int burst;
      rst         = 1'b1;
      jump_ena_i  = 1'b0;
      jump_addr_i = '0;
      hold_flag_i = 1'b0;
      ext_hold_i  = 1'b0;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      check_outputs("reset");
      rst = 1'b0;

      // Single jump: one-cycle redirect, two-cycle flush.
      cycle("t1_jump", 1'b1, 32'h0000_0040, 1'b0, 1'b0);
      check("t1_redirect_pulse", 32'(redirect_o), 32'd1);
      check("t1_redirect_addr",  redirect_addr_o, 32'h0000_0040);
      for (int i = 0; i < 4; i++) cycle("t1_idle", 1'b0, 32'h0, 1'b0, 1'b0);

      // hold_flag for 5 cycles, zero-latency hold.
      for (int i = 0; i < 5; i++) cycle("t2_hold", 1'b0, 32'h0, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) cycle("t2_idle", 1'b0, 32'h0, 1'b0, 1'b0);

      // Jump and hold together: jump wins.
      jump_ena_i = 1'b1; hold_flag_i = 1'b1; #1;
      check("t3_hold_masked", 32'(hold_o), 32'd0);
      cycle("t3_jump_hold", 1'b1, 32'h0000_0100, 1'b1, 1'b0);
      check("t3_addr", redirect_addr_o, 32'h0000_0100);
      for (int i = 0; i < 4; i++) cycle("t3_tail", 1'b0, 32'h0, 1'b0, 1'b0);

      // Jumps during every FLUSH cycle are ignored.
      cycle("t4_jump", 1'b1, 32'h0000_0040, 1'b0, 1'b0);
      cycle("t4_wrong1", 1'b1, 32'h0000_0080, 1'b0, 1'b0);
      cycle("t4_wrong2", 1'b1, 32'h0000_0080, 1'b1, 1'b0);
      check("t4_addr_kept", redirect_addr_o, 32'h0000_0040);
      for (int i = 0; i < 3; i++) cycle("t4_tail", 1'b0, 32'h0, 1'b0, 1'b0);

      // Long external stall trips the sticky watchdog.
      for (int i = 0; i < 70; i++) cycle("t5_ext", 1'b0, 32'h0, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) cycle("t5_rel", 1'b0, 32'h0, 1'b0, 1'b0);
      check("t5_timeout_sticky", 32'(hold_timeout_o), 32'd1);

      // Reset in the middle of FLUSH.
      cycle("t6_jump", 1'b1, 32'h0000_0200, 1'b0, 1'b1);
      do_reset("t6");
      for (int i = 0; i < 3; i++) cycle("t6_after", 1'b0, 32'h0, 1'b0, 1'b1);

      // Randomized traffic with bursty external stalls and one reset pulse.
      burst = 0;
      for (int i = 0; i < 800; i++) begin
         logic je, hf, eh;
         if (burst == 0 && $urandom_range(0, 9) == 0) burst = $urandom_range(1, 80);
         eh = (burst > 0);
         if (burst > 0) burst--;
         je = ($urandom_range(0, 5) == 0);
         hf = ($urandom_range(0, 3) == 0);
         if (i == 400) do_reset("rnd");
         cycle("rnd", je, $urandom, hf, eh);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
